// File: rtl/prefix_state.sv
// prefix_state: per-instruction prefix tracker sitting between decode and the
// microcode sequencer. It tracks segment override, REP/REPNE and LOCK
// prefixes, and a saturating prefix count with a sticky overflow flag. A
// shadow copy lets an interrupted REP string instruction restart with its
// original prefixes.
module prefix_state #(
   parameter int SEG_W        = 2,
   parameter int SS_SEL       = 2,
   parameter int MAX_PREFIXES = 14,
   parameter int CNT_W        = $clog2(MAX_PREFIXES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             next_instruction,
   input  logic             flush,
   input  logic             prefix_valid,
   input  logic [1:0]       prefix_type,
   input  logic [SEG_W-1:0] prefix_seg,
   input  logic             save,
   input  logic             restore,
   input  logic             force_segment,
   input  logic             bp_is_base,
   input  logic [SEG_W-1:0] microcode_sr_rd_sel,
   output logic [SEG_W-1:0] sr_rd_sel,
   output logic             rep_active,
   output logic             rep_z,
   output logic             lock_active,
   output logic [CNT_W-1:0] prefix_count,
   output logic             prefix_overflow
);

   localparam logic [1:0]       PT_SEG   = 2'b00;
   localparam logic [1:0]       PT_REP   = 2'b01;
   localparam logic [1:0]       PT_REPNE = 2'b10;
   localparam logic [1:0]       PT_LOCK  = 2'b11;
   localparam logic [SEG_W-1:0] SS_VAL   = SEG_W'(SS_SEL);
   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PREFIXES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // One complete set of prefix state; the live and shadow copies share it.
   typedef struct packed {
      logic             seg_active;
      logic [SEG_W-1:0] seg;
      logic             rep_active;
      logic             rep_z;
      logic             lock_active;
      logic [CNT_W-1:0] count;
      logic             overflow;
   } pstate_t;

   pstate_t live_r;
   pstate_t shadow_r;
   pstate_t live_next_s;
   pstate_t shadow_next_s;

   // Applies one decoded prefix byte to a state snapshot. Later prefixes of
   // the same kind overwrite earlier ones; the counter saturates instead of
   // wrapping and latches overflow on the first prefix beyond the limit.
   function automatic pstate_t apply_prefix(input pstate_t cur,
                                            input logic [1:0] ptype,
                                            input logic [SEG_W-1:0] pseg);
      pstate_t nxt;
      nxt = cur;
      case (ptype)
         PT_SEG: begin
            nxt.seg        = pseg;
            nxt.seg_active = 1'b1;
         end
         PT_REP: begin
            nxt.rep_active = 1'b1;
            nxt.rep_z      = 1'b1;
         end
         PT_REPNE: begin
            nxt.rep_active = 1'b1;
            nxt.rep_z      = 1'b0;
         end
         PT_LOCK: begin
            nxt.lock_active = 1'b1;
         end
         default: begin
            nxt = cur;
         end
      endcase
      if (cur.count < MAX_CNT) begin
         nxt.count = cur.count + CNT_ONE;
      end else begin
         nxt.overflow = 1'b1;
      end
      return nxt;
   endfunction

   // Next-state selection: flush beats restore beats instruction boundary;
   // a prefix arriving with the boundary lands on the freshly cleared state.
   always_comb begin
      live_next_s   = live_r;
      shadow_next_s = shadow_r;
      if (flush) begin
         live_next_s   = '0;
         shadow_next_s = '0;
      end else begin
         if (restore) begin
            live_next_s = shadow_r;
         end else if (next_instruction) begin
            if (prefix_valid) begin
               live_next_s = apply_prefix('0, prefix_type, prefix_seg);
            end else begin
               live_next_s = '0;
            end
         end else if (prefix_valid) begin
            live_next_s = apply_prefix(live_r, prefix_type, prefix_seg);
         end else begin
            live_next_s = live_r;
         end
         // The shadow captures what live becomes, including this cycle's prefix.
         if (save && !restore) begin
            shadow_next_s = live_next_s;
         end else begin
            shadow_next_s = shadow_r;
         end
      end
   end

   // Live and shadow state registers with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         live_r   <= '0;
         shadow_r <= '0;
      end else begin
         live_r   <= live_next_s;
         shadow_r <= shadow_next_s;
      end
   end

   // Segment read select: microcode force, then same-cycle prefix bypass,
   // then the latched override, then the BP-implied stack segment.
   always_comb begin
      sr_rd_sel = microcode_sr_rd_sel;
      if (force_segment) begin
         sr_rd_sel = microcode_sr_rd_sel;
      end else if (prefix_valid && (prefix_type == PT_SEG)) begin
         sr_rd_sel = prefix_seg;
      end else if (live_r.seg_active) begin
         sr_rd_sel = live_r.seg;
      end else if (bp_is_base) begin
         sr_rd_sel = SS_VAL;
      end else begin
         sr_rd_sel = microcode_sr_rd_sel;
      end
   end

   assign rep_active      = live_r.rep_active;
   assign rep_z           = live_r.rep_z;
   assign lock_active     = live_r.lock_active;
   assign prefix_count    = live_r.count;
   assign prefix_overflow = live_r.overflow;

endmodule

// File: tb/tb_prefix_state.sv
// tb_prefix_state: scoreboard bench for prefix_state. The driver applies one
// input vector per cycle and pushes the expected response; a monitor pops and
// compares. The reference model keeps each instruction as a list of the
// prefix bytes seen so far and derives every output from that list.
module tb_prefix_state;

   localparam int SEG_W = 2;
   localparam int MAXP  = 14;
   localparam int CNT_W = 4;
   localparam int SS    = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             next_instruction;
   logic             flush;
   logic             prefix_valid;
   logic [1:0]       prefix_type;
   logic [SEG_W-1:0] prefix_seg;
   logic             save;
   logic             restore;
   logic             force_segment;
   logic             bp_is_base;
   logic [SEG_W-1:0] microcode_sr_rd_sel;
   logic [SEG_W-1:0] sr_rd_sel;
   logic             rep_active;
   logic             rep_z;
   logic             lock_active;
   logic [CNT_W-1:0] prefix_count;
   logic             prefix_overflow;

   prefix_state #(.SEG_W(SEG_W), .SS_SEL(SS), .MAX_PREFIXES(MAXP)) dut (
      .clk(clk), .reset(reset), .next_instruction(next_instruction),
      .flush(flush), .prefix_valid(prefix_valid), .prefix_type(prefix_type),
      .prefix_seg(prefix_seg), .save(save), .restore(restore),
      .force_segment(force_segment), .bp_is_base(bp_is_base),
      .microcode_sr_rd_sel(microcode_sr_rd_sel), .sr_rd_sel(sr_rd_sel),
      .rep_active(rep_active), .rep_z(rep_z), .lock_active(lock_active),
      .prefix_count(prefix_count), .prefix_overflow(prefix_overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      int sr;
      int rep;
      int repz;
      int lock;
      int cnt;
      int ovf;
   } exp_t;

   exp_t exp_q[$];
   int   live_q[$];    // prefix bytes of the current instruction: type*16 + seg
   int   shadow_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
      end
   endtask

   // Segment select seen this cycle, from the pre-edge prefix list.
   function automatic int model_sr(input int fs, input int pv, input int pt,
                                   input int ps, input int bp, input int mc);
      if (fs != 0) return mc;
      if (pv != 0 && pt == 0) return ps;
      for (int i = live_q.size() - 1; i >= 0; i--) begin
         if ((live_q[i] / 16) == 0) return live_q[i] % 16;
      end
      if (bp != 0) return SS;
      return mc;
   endfunction

   // Registered outputs derived from the current prefix list.
   function automatic exp_t model_regs();
      exp_t e;
      e.sr = 0; e.rep = 0; e.repz = 0; e.lock = 0; e.ovf = 0;
      foreach (live_q[i]) begin
         case (live_q[i] / 16)
            1: begin e.rep = 1; e.repz = 1; end
            2: begin e.rep = 1; e.repz = 0; end
            3: e.lock = 1;
            default: ;
         endcase
      end
      e.cnt = (live_q.size() > MAXP) ? MAXP : live_q.size();
      e.ovf = (live_q.size() > MAXP) ? 1 : 0;
      return e;
   endfunction

   task automatic step(input int nxt, input int fl, input int pv, input int pt,
                       input int ps, input int sv, input int rs, input int fs,
                       input int bp, input int mc, input int rst = 0);
      exp_t e;
      int   sr_now;
      @(negedge clk);
      reset               = (rst != 0);
      next_instruction    = (nxt != 0);
      flush               = (fl != 0);
      prefix_valid        = (pv != 0);
      prefix_type         = 2'(pt);
      prefix_seg          = SEG_W'(ps);
      save                = (sv != 0);
      restore             = (rs != 0);
      force_segment       = (fs != 0);
      bp_is_base          = (bp != 0);
      microcode_sr_rd_sel = SEG_W'(mc);
      if (rst != 0) begin
         live_q.delete();
         shadow_q.delete();
      end
      sr_now = model_sr(fs, pv, pt, ps, bp, mc);
      if (rst == 0) begin
         if (fl != 0) begin
            live_q.delete();
            shadow_q.delete();
         end else if (rs != 0) begin
            live_q = shadow_q;
         end else begin
            if (nxt != 0) live_q.delete();
            if (pv != 0) live_q.push_back(pt * 16 + ps);
            if (sv != 0) shadow_q = live_q;
         end
      end
      e = model_regs();
      e.sr = sr_now;
      exp_q.push_back(e);
   endtask

   // Monitor: combinational select before the edge, registers after it.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sr_rd_sel", int'(sr_rd_sel), e.sr);
            @(posedge clk);
            #1;
            chk("rep_active", int'(rep_active), e.rep);
            chk("rep_z", int'(rep_z), e.repz);
            chk("lock_active", int'(lock_active), e.lock);
            chk("prefix_count", int'(prefix_count), e.cnt);
            chk("prefix_overflow", int'(prefix_overflow), e.ovf);
         end
      end
   end

   // Hard time limit so the run can never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; next_instruction = 1'b0; flush = 1'b0; prefix_valid = 1'b0;
      prefix_type = 2'd0; prefix_seg = 2'd0; save = 1'b0; restore = 1'b0;
      force_segment = 1'b0; bp_is_base = 1'b0; microcode_sr_rd_sel = 2'd0;
      repeat (2) @(negedge clk);
      // reset state, BP default and forced segment
      step(0,0,0,0,0, 0,0,0,1,3, 1);
      step(0,0,0,0,0, 0,0,0,1,3);
      step(0,0,0,0,0, 0,0,1,1,3);
      // two segment prefixes with bypass, then instruction boundary
      step(0,0,1,0,0, 0,0,0,1,3);
      step(0,0,1,0,1, 0,0,0,1,3);
      step(0,0,0,0,0, 0,0,0,1,3);
      step(1,0,0,0,0, 0,0,0,1,3);
      step(0,0,0,0,0, 0,0,0,1,3);
      // REPNE, LOCK, REP
      step(0,0,1,2,0, 0,0,0,0,1);
      step(0,0,1,3,0, 0,0,0,0,1);
      step(0,0,1,1,0, 0,0,0,0,1);
      step(0,0,0,0,0, 0,0,0,0,1);
      // saturation: 15 prefixes then boundary
      step(1,0,0,0,0, 0,0,0,0,0);
      for (int i = 0; i < 15; i++) step(0,0,1,$urandom_range(3),$urandom_range(3), 0,0,0,0,0);
      step(0,0,0,0,0, 0,0,0,0,0);
      step(1,0,0,0,0, 0,0,0,0,0);
      step(0,0,0,0,0, 0,0,0,0,0);
      // save / restore of an interrupted REP instruction
      step(0,0,1,0,3, 0,0,0,1,0);
      step(0,0,1,1,0, 1,0,0,1,0);
      step(1,0,0,0,0, 0,0,0,1,0);
      step(0,0,1,0,1, 0,0,0,1,0);
      step(0,0,0,0,0, 0,1,0,1,0);
      step(0,0,0,0,0, 0,0,0,1,0);
      step(0,1,0,0,0, 0,1,0,1,0);
      step(0,0,0,0,0, 0,0,0,1,0);
      // boundary and segment prefix in the same cycle
      step(1,0,1,0,2, 0,0,0,0,1);
      step(0,0,0,0,0, 0,0,0,0,1);
      // asynchronous reset in the middle of an instruction
      step(0,0,1,1,0, 1,0,0,0,0);
      step(0,0,1,0,3, 0,0,0,0,0);
      step(0,0,1,0,1, 0,0,0,1,0, 1);
      step(0,0,0,0,0, 0,1,0,1,0);
      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(9) == 0) ? 1 : 0,
              ($urandom_range(29) == 0) ? 1 : 0,
              $urandom_range(1),
              $urandom_range(3),
              $urandom_range(3),
              ($urandom_range(9) == 0) ? 1 : 0,
              ($urandom_range(15) == 0) ? 1 : 0,
              ($urandom_range(6) == 0) ? 1 : 0,
              $urandom_range(1),
              $urandom_range(3),
              ($urandom_range(99) == 0) ? 1 : 0);
      end
      step(0,0,0,0,0, 0,0,0,0,0);
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
